// File: rtl/sr_debug_dump.sv
// ---------------------------------------------------------------------------
// sr_debug_dump
//
// Purpose:
//   Reads the CPU debug register port and sends the values out as a byte
//   stream. A start pulse walks debug addresses FIRST_REG..LAST_REG. Each
//   address is given one settle cycle, then the 32-bit value is captured.
//   The value is sent as four bytes, least significant byte first, on a
//   valid/ready stream (for example toward a UART TX or a host bridge).
//   Address 0 returns the pc, so the default dump is pc, x1..x31.
//
// Optional feature:
//   Define SR_DEBUG_DUMP_HEADER_EN to send a two-byte header before the
//   first word: 0xA5, then the word count (LAST_REG-FIRST_REG+1).
//   Without the macro the header state and its logic are not built.
//
// Parameters:
//   FIRST_REG  first debug address read (0..31)
//   LAST_REG   last debug address read (FIRST_REG..31)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle request to begin a dump (ignored while busy)
//   regAddr    debug register address driven to the CPU
//   regData    debug register data from the CPU (combinational from regAddr)
//   out_data   stream byte
//   out_valid  out_data is valid
//   out_ready  downstream accepts the byte on out_valid & out_ready
//   busy       dump in progress
//   done       one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module sr_debug_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  // Reject address ranges that cannot be walked with a 5-bit non-wrapping
  // increment.
  generate
    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : gBadParams
      $error("sr_debug_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
    end
  endgenerate

  localparam logic [4:0] FirstAddr = 5'(FIRST_REG);
  localparam logic [4:0] LastAddr  = 5'(LAST_REG);
`ifdef SR_DEBUG_DUMP_HEADER_EN
  localparam logic [7:0] HeaderMagic = 8'hA5;
  localparam logic [7:0] WordCount   = 8'(LAST_REG - FIRST_REG + 1);
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
`ifdef SR_DEBUG_DUMP_HEADER_EN
    HDR   = 3'd1,
`endif
    ADDR  = 3'd2,
    LATCH = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] shiftReg;
  logic [31:0] shiftNext;
  logic [1:0]  byteCnt;
  logic [1:0]  byteCntNext;
  logic [4:0]  addrNext;
  logic [7:0]  dataNext;
  logic        validNext;
  logic        busyNext;
  logic        doneNext;
  logic        accept;
`ifdef SR_DEBUG_DUMP_HEADER_EN
  logic        hdrCnt;
  logic        hdrCntNext;
`endif

  assign accept = out_valid & out_ready;

  // State and datapath registers. Every output is registered, so the stream
  // stays glitch-free. The asynchronous reset drops out_valid immediately,
  // which aborts a dump in progress without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      regAddr   <= 5'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shiftReg  <= 32'd0;
      byteCnt   <= 2'd0;
`ifdef SR_DEBUG_DUMP_HEADER_EN
      hdrCnt    <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      regAddr   <= addrNext;
      out_data  <= dataNext;
      out_valid <= validNext;
      busy      <= busyNext;
      done      <= doneNext;
      shiftReg  <= shiftNext;
      byteCnt   <= byteCntNext;
`ifdef SR_DEBUG_DUMP_HEADER_EN
      hdrCnt    <= hdrCntNext;
`endif
    end
  end

  // Next-state and next-output logic. By default everything holds its value
  // and done is low, so done can only be high for the single cycle spent in
  // DONE. A start outside IDLE is not handled in any branch, which means it
  // is dropped rather than queued.
  always_comb begin
    stateNext   = state;
    addrNext    = regAddr;
    dataNext    = out_data;
    validNext   = out_valid;
    busyNext    = busy;
    doneNext    = 1'b0;
    shiftNext   = shiftReg;
    byteCntNext = byteCnt;
`ifdef SR_DEBUG_DUMP_HEADER_EN
    hdrCntNext  = hdrCnt;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          busyNext = 1'b1;
          addrNext = FirstAddr;
`ifdef SR_DEBUG_DUMP_HEADER_EN
          dataNext   = HeaderMagic;
          validNext  = 1'b1;
          hdrCntNext = 1'b0;
          stateNext  = HDR;
`else
          stateNext  = ADDR;
`endif
        end
      end

`ifdef SR_DEBUG_DUMP_HEADER_EN
      HDR: begin
        if (accept) begin
          if (!hdrCnt) begin
            dataNext   = WordCount;
            hdrCntNext = 1'b1;
          end else begin
            validNext  = 1'b0;
            stateNext  = ADDR;
          end
        end
      end
`endif

      ADDR: begin
        stateNext = LATCH;
      end

      // Snapshot the whole word here. A long stall in SEND then cannot mix
      // bytes from two different register values.
      LATCH: begin
        shiftNext   = regData;
        byteCntNext = 2'd0;
        dataNext    = regData[7:0];
        validNext   = 1'b1;
        stateNext   = SEND;
      end

      SEND: begin
        if (accept) begin
          shiftNext   = {8'h00, shiftReg[31:8]};
          byteCntNext = 2'(byteCnt + 2'd1);
          dataNext    = shiftReg[15:8];
          if (byteCnt == 2'd3) begin
            validNext = 1'b0;
            if (regAddr == LastAddr) begin
              doneNext  = 1'b1;
              busyNext  = 1'b0;
              addrNext  = 5'd0;
              stateNext = DONE;
            end else begin
              addrNext  = regAddr + 5'd1;
              stateNext = ADDR;
            end
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_debug_dump.sv
// ---------------------------------------------------------------------------
// tb_sr_debug_dump
//
// Testbench for sr_debug_dump with two instances:
//   uDefault  FIRST_REG=0, LAST_REG=31. Its CPU model returns
//             32'h1000_0000 + addr.
//   uSingle   FIRST_REG=LAST_REG=5. Its CPU model returns 32'hDEADBEEF at
//             address 5.
// Expected bytes go into a scoreboard queue when a dump is requested. They
// are popped and compared each time the selected instance hands over a byte.
// ---------------------------------------------------------------------------
module tb_sr_debug_dump;

`ifdef SR_DEBUG_DUMP_HEADER_EN
  localparam int HDR_BYTES = 2;
`else
  localparam int HDR_BYTES = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        startReq;
  logic        sel;
  logic        ready;

  logic        startA;
  logic        startB;
  logic [4:0]  regAddrA;
  logic [4:0]  regAddrB;
  logic [31:0] regDataA;
  logic [31:0] regDataB;
  logic [7:0]  dataA;
  logic [7:0]  dataB;
  logic        validA;
  logic        validB;
  logic        busyA;
  logic        busyB;
  logic        doneA;
  logic        doneB;

  logic [7:0]  curData;
  logic        curValid;
  logic        curBusy;
  logic        curDone;
  logic [4:0]  curAddr;

  logic [7:0]  expQ[$];
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign startA   = startReq & ~sel;
  assign startB   = startReq & sel;
  assign regDataA = 32'h1000_0000 + {27'd0, regAddrA};
  assign regDataB = (regAddrB == 5'd5) ? 32'hDEAD_BEEF : (32'hBAD0_0000 | {27'd0, regAddrB});

  assign curData  = sel ? dataB    : dataA;
  assign curValid = sel ? validB   : validA;
  assign curBusy  = sel ? busyB    : busyA;
  assign curDone  = sel ? doneB    : doneA;
  assign curAddr  = sel ? regAddrB : regAddrA;

  sr_debug_dump uDefault (
    .clk(clk), .rst_n(rst_n), .start(startA), .regAddr(regAddrA), .regData(regDataA),
    .out_data(dataA), .out_valid(validA), .out_ready(ready), .busy(busyA), .done(doneA)
  );

  sr_debug_dump #(.FIRST_REG(5), .LAST_REG(5)) uSingle (
    .clk(clk), .rst_n(rst_n), .start(startB), .regAddr(regAddrB), .regData(regDataB),
    .out_data(dataB), .out_valid(validB), .out_ready(ready), .busy(busyB), .done(doneB)
  );

  // Push the bytes one dump is expected to send: the optional header, then
  // each word least significant byte first.
  task automatic pushDump(input int first, input int last, input bit singleDut);
    logic [31:0] w;
`ifdef SR_DEBUG_DUMP_HEADER_EN
    expQ.push_back(8'hA5);
    expQ.push_back(8'(last - first + 1));
`endif
    for (int a = first; a <= last; a++) begin
      w = singleDut ? 32'hDEAD_BEEF : (32'h1000_0000 + 32'(a));
      for (int b = 0; b < 4; b++) expQ.push_back(w[8*b +: 8]);
    end
  endtask

  // Pulse start in cycle 0, then run the instance picked by sel. Each
  // accepted byte is popped from the scoreboard and compared. Extra start
  // pulses can be injected at chosen cycles. The run stops 8 cycles after the
  // expected number of done pulses, or when maxCycles runs out.
  task automatic applyStimulus(input bit randReady, input int startAt1, input int startAt2,
                               input int expDones, input int maxCycles,
                               input int addrLo, input int addrHi,
                               output int nBytes, output int nDone, output int doneCycle,
                               output int firstDataCycle, output int holdErrs,
                               output int busyErrs, output int addrErrs);
    int cyc;
    int tail;
    bit pend;
    logic [7:0] held;
    logic [7:0] expByte;
    nBytes = 0; nDone = 0; doneCycle = -1; firstDataCycle = -1;
    holdErrs = 0; busyErrs = 0; addrErrs = 0;
    cyc = 0; tail = 0; pend = 1'b0; held = 8'd0;
    @(negedge clk);
    startReq = 1'b1;
    ready = 1'b1;
    while (cyc < maxCycles && tail < 8) begin
      @(negedge clk);
      cyc++;
      startReq = (cyc == startAt1) || (cyc == startAt2);
      ready = randReady ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (pend && (curValid !== 1'b1 || curData !== held)) holdErrs++;
      if (curDone === 1'b1) begin
        nDone++;
        if (doneCycle < 0) doneCycle = cyc;
      end else if (nDone == 0 && curBusy !== 1'b1) begin
        busyErrs++;
      end
      if (curBusy === 1'b1 && (int'(curAddr) < addrLo || int'(curAddr) > addrHi)) addrErrs++;
      if (curValid === 1'b1 && ready) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL extra_byte: got %02h, required no byte", curData);
        end else begin
          expByte = expQ.pop_front();
          if (curData !== expByte) begin
            failures++;
            $display("[TB] FAIL byte[%0d]: got %02h, required %02h", nBytes, curData, expByte);
          end
        end
        if (nBytes == HDR_BYTES && firstDataCycle < 0) firstDataCycle = cyc;
        nBytes++;
        pend = 1'b0;
      end else begin
        pend = (curValid === 1'b1);
        held = curData;
      end
      if (nDone >= expDones) tail++;
    end
    startReq = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    sel = 1'b0; startReq = 1'b0; ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (regAddrA !== 5'd0) begin failures++; $display("[TB] FAIL reset_regAddr: got %0d, required 0", regAddrA); end
    if (validA !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b, required 0", validA); end
    if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, required 0", busyA); end
    if (doneA !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, required 0", doneA); end
    if (dataA !== 8'd0) begin failures++; $display("[TB] FAIL reset_out_data: got %02h, required 00", dataA); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_send();
    int waitCyc;
    $display("[TB] test_reset_mid_send");
    sel = 1'b0; ready = 1'b0;
    startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    waitCyc = 0;
    while (validA !== 1'b1 && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    checks++;
    if (validA !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midsend_valid_timeout: got out_valid=%b, required 1", validA);
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (validA !== 1'b0) begin failures++; $display("[TB] FAIL midsend_async_valid: got %b, required 0", validA); end
    if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL midsend_async_busy: got %b, required 0", busyA); end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_dump();
    int nb, nd, dc, fd, he, be, ae;
    $display("[TB] test_default_dump");
    sel = 1'b0;
    expQ.delete();
    pushDump(0, 31, 1'b0);
    applyStimulus(1'b0, -1, -1, 1, 400, 0, 31, nb, nd, dc, fd, he, be, ae);
    checks += 6;
    if (nb !== 128 + HDR_BYTES) begin failures++; $display("[TB] FAIL default_bytes: got %0d, required %0d", nb, 128 + HDR_BYTES); end
    if (nd !== 1) begin failures++; $display("[TB] FAIL default_done_count: got %0d, required 1", nd); end
    if (dc !== 193 + HDR_BYTES) begin failures++; $display("[TB] FAIL default_done_cycle: got %0d, required %0d", dc, 193 + HDR_BYTES); end
    if (fd !== 3 + HDR_BYTES) begin failures++; $display("[TB] FAIL default_first_data: got %0d, required %0d", fd, 3 + HDR_BYTES); end
    if (be !== 0) begin failures++; $display("[TB] FAIL default_busy_gap: got %0d low cycles, required 0", be); end
    if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL default_leftover: got %0d unsent, required 0", expQ.size()); end
  endtask

  task automatic test_backpressure();
    int nb, nd, dc, fd, he, be, ae;
    $display("[TB] test_backpressure");
    sel = 1'b0;
    expQ.delete();
    pushDump(0, 31, 1'b0);
    applyStimulus(1'b1, -1, -1, 1, 5000, 0, 31, nb, nd, dc, fd, he, be, ae);
    checks += 5;
    if (nb !== 128 + HDR_BYTES) begin failures++; $display("[TB] FAIL bp_bytes: got %0d, required %0d", nb, 128 + HDR_BYTES); end
    if (nd !== 1) begin failures++; $display("[TB] FAIL bp_done_count: got %0d, required 1", nd); end
    if (he !== 0) begin failures++; $display("[TB] FAIL bp_hold_stable: got %0d changes, required 0", he); end
    if (be !== 0) begin failures++; $display("[TB] FAIL bp_busy_gap: got %0d low cycles, required 0", be); end
    if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL bp_leftover: got %0d unsent, required 0", expQ.size()); end
  endtask

  task automatic test_single_word();
    int nb, nd, dc, fd, he, be, ae;
    $display("[TB] test_single_word");
    sel = 1'b1;
    expQ.delete();
    pushDump(5, 5, 1'b1);
    applyStimulus(1'b0, -1, -1, 1, 100, 5, 5, nb, nd, dc, fd, he, be, ae);
    checks += 4;
    if (nb !== 4 + HDR_BYTES) begin failures++; $display("[TB] FAIL single_bytes: got %0d, required %0d", nb, 4 + HDR_BYTES); end
    if (nd !== 1 || dc !== 7 + HDR_BYTES) begin failures++; $display("[TB] FAIL single_done: got count %0d cycle %0d, required 1 at %0d", nd, dc, 7 + HDR_BYTES); end
    if (ae !== 0) begin failures++; $display("[TB] FAIL single_regAddr: got %0d cycles off 5, required 0", ae); end
    if (regAddrB !== 5'd0) begin failures++; $display("[TB] FAIL single_addr_idle: got %0d, required 0", regAddrB); end
    sel = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int nb, nd, dc, fd, he, be, ae;
    $display("[TB] test_start_while_busy");
    sel = 1'b0;
    expQ.delete();
    pushDump(0, 31, 1'b0);
    applyStimulus(1'b0, 63 + HDR_BYTES, 193 + HDR_BYTES, 1, 400, 0, 31, nb, nd, dc, fd, he, be, ae);
    checks += 3;
    if (nb !== 128 + HDR_BYTES) begin failures++; $display("[TB] FAIL busy_start_bytes: got %0d, required %0d", nb, 128 + HDR_BYTES); end
    if (nd !== 1) begin failures++; $display("[TB] FAIL busy_start_done: got %0d, required 1", nd); end
    if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL busy_start_idle: got busy=%b, required 0", busyA); end
  endtask

  task automatic test_back_to_back();
    int nb, nd, dc, fd, he, be, ae;
    $display("[TB] test_back_to_back");
    sel = 1'b0;
    expQ.delete();
    pushDump(0, 31, 1'b0);
    pushDump(0, 31, 1'b0);
    applyStimulus(1'b0, 194 + HDR_BYTES, -1, 2, 800, 0, 31, nb, nd, dc, fd, he, be, ae);
    checks += 3;
    if (nb !== 2 * (128 + HDR_BYTES)) begin failures++; $display("[TB] FAIL b2b_bytes: got %0d, required %0d", nb, 2 * (128 + HDR_BYTES)); end
    if (nd !== 2) begin failures++; $display("[TB] FAIL b2b_done: got %0d, required 2", nd); end
    if (expQ.size() !== 0) begin failures++; $display("[TB] FAIL b2b_leftover: got %0d unsent, required 0", expQ.size()); end
  endtask

  // Run the scenarios in sequence and print the summary.
  initial begin
    checks = 0;
    failures = 0;
    sel = 1'b0;
    startReq = 1'b0;
    ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_reset_mid_send();
    test_default_dump();
    test_backpressure();
    test_single_word();
    test_start_while_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
